// File: rtl/hist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hist_pkg
//  Description : Shared types and constants for the histogram readout
//                transmitter: FSM state encoding, default frame marker,
//                clear-pulse length and frame length helper.
//  Revision    : 1.0  initial release
// ============================================================================
package hist_pkg;

    // Readout FSM states; CLEAR is only reachable with HIST_CLEAR_AFTER_READ_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNAP  = 3'd1,
        ST_HDR   = 3'd2,
        ST_CNT   = 3'd3,
        ST_DATA  = 3'd4,
        ST_CSUM  = 3'd5,
        ST_CLEAR = 3'd6
    } hist_state_e;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    // Long enough to pass through the histogram block's 2-stage synchronizer
    localparam int CLEAR_CYCLES = 4;

    // Header + count + payload + checksum
    function automatic int frame_len(input int nbins, input int binw);
        return 3 + nbins * (binw / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hist_byte_mux.sv
`default_nettype none
// ============================================================================
//  Module      : hist_byte_mux
//  Description : Combinational selection of byte [byte_idx] of snapshot
//                entry [bin_idx]. Out-of-range indices return 0.
//  Revision    : 1.0  initial release
// ============================================================================
module hist_byte_mux #(
    parameter int NBINS = 8,
    parameter int BINW  = 32
) (
    input  logic [NBINS*BINW-1:0] snap,
    input  logic [7:0]            bin_idx,
    input  logic [1:0]            byte_idx,
    output logic [7:0]            data_byte
);

    // Select one byte of the snapshot; entries are packed LSB-first
    always_comb begin
        data_byte = 8'h00;
        for (int i = 0; i < NBINS; i++) begin
            for (int j = 0; j < BINW / 8; j++) begin
                if (bin_idx == 8'(i) && byte_idx == 2'(j)) begin
                    data_byte = snap[i*BINW + j*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hist_readout_tx.sv
`default_nettype none
// ============================================================================
//  Module      : hist_readout_tx
//  Description : Snapshots NBINS histogram words on a start rising edge and
//                streams them as a framed byte sequence
//                (HDR, COUNT, DATA LSB-first, XOR checksum) over a
//                valid/ready byte interface.
//                Optional macro HIST_CLEAR_AFTER_READ_EN: after the frame,
//                hold resethist high for CLEAR_CYCLES cycles before idling.
//  Revision    : 1.0  initial release
// ============================================================================
module hist_readout_tx
    import hist_pkg::*;
#(
    parameter int         NBINS    = 8,
    parameter int         BINW     = 32,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic                  clkin,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [NBINS*BINW-1:0] hist_flat,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  resethist
);

    localparam logic [1:0] LAST_BYTE = 2'(BINW / 8 - 1);
    localparam logic [7:0] LAST_BIN  = 8'(NBINS - 1);
    localparam logic [7:0] CNT_BYTE  = 8'(NBINS);

    hist_state_e           state;
    logic                  start_d;
    logic                  start_rise;
    logic                  xfer;
    logic [NBINS*BINW-1:0] snap;
    logic [7:0]            bin_idx;
    logic [1:0]            byte_idx;
    logic [7:0]            csum;
    logic [7:0]            data_byte;

    assign start_rise = start & ~start_d;
    assign xfer       = tx_valid & tx_ready;

    // Outputs decode directly from the state register so reset clears them at once
    assign tx_valid = (state == ST_HDR) || (state == ST_CNT) ||
                      (state == ST_DATA) || (state == ST_CSUM);
    assign busy     = (state != ST_IDLE);

    hist_byte_mux #(
        .NBINS (NBINS),
        .BINW  (BINW)
    ) u_byte_mux (
        .snap      (snap),
        .bin_idx   (bin_idx),
        .byte_idx  (byte_idx),
        .data_byte (data_byte)
    );

    // Byte presented to the sink; stable while stalled because it depends only on registers
    always_comb begin
        case (state)
            ST_HDR:  tx_data = HDR_BYTE;
            ST_CNT:  tx_data = CNT_BYTE;
            ST_DATA: tx_data = data_byte;
            ST_CSUM: tx_data = csum;
            default: tx_data = 8'h00;
        endcase
    end

`ifdef HIST_CLEAR_AFTER_READ_EN
    logic [2:0] clr_cnt;

    assign resethist = (state == ST_CLEAR);

    // Counts cycles spent in CLEAR
    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            clr_cnt <= 3'd0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 3'd1;
        end else begin
            clr_cnt <= 3'd0;
        end
    end
`else
    assign resethist = 1'b0;
`endif

    // Start edge detector history
    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            start_d <= 1'b0;
        end else begin
            start_d <= start;
        end
    end

    // Readout FSM with snapshot, index counters, checksum and done pulse
    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            snap     <= '0;
            bin_idx  <= 8'd0;
            byte_idx <= 2'd0;
            csum     <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (xfer && state != ST_CSUM) begin
                csum <= csum ^ tx_data;
            end
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    snap     <= hist_flat;
                    csum     <= 8'h00;
                    bin_idx  <= 8'd0;
                    byte_idx <= 2'd0;
                    state    <= ST_HDR;
                end
                ST_HDR: begin
                    if (xfer) begin
                        state <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (xfer) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx <= 2'd0;
                            if (bin_idx == LAST_BIN) begin
                                state <= ST_CSUM;
                            end else begin
                                bin_idx <= bin_idx + 8'd1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        done <= 1'b1;
`ifdef HIST_CLEAR_AFTER_READ_EN
                        state <= ST_CLEAR;
`else
                        state <= ST_IDLE;
`endif
                    end
                end
`ifdef HIST_CLEAR_AFTER_READ_EN
                ST_CLEAR: begin
                    if (clr_cnt == 3'(CLEAR_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hist_readout_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hist_readout_tx
//  Description : Directed self-checking bench for hist_readout_tx
//                (NBINS=8, BINW=32). Honours HIST_CLEAR_AFTER_READ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hist_readout_tx;
    import hist_pkg::*;

    localparam int NBINS = 8;
    localparam int BINW  = 32;
    localparam int FW    = NBINS * BINW;
    localparam int FLEN  = frame_len(NBINS, BINW);
`ifdef HIST_CLEAR_AFTER_READ_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clkin;
    logic          nrst;
    logic          start;
    logic [FW-1:0] hist_flat;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;
    logic          resethist;

    hist_readout_tx #(
        .NBINS    (NBINS),
        .BINW     (BINW),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clkin     (clkin),
        .nrst      (nrst),
        .start     (start),
        .hist_flat (hist_flat),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .done      (done),
        .resethist (resethist)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_xfer_cyc = 0;
    logic       done_busy = 1'b0;
    int         rh_cnt = 0;
    int         rh_total = 0;
    int         rh_bad = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    bit         ready_mode = 1'b0;
    int         ph = 0;
    logic [FW-1:0] h1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame built from the histogram image
    task automatic build_exp(input logic [FW-1:0] h);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NBINS));
        for (int i = 0; i < NBINS; i++)
            for (int b = 0; b < BINW / 8; b++)
                exp_q.push_back(h[i*BINW + b*8 +: 8]);
        x = 8'h00;
        foreach (exp_q[k]) x = x ^ exp_q[k];
        exp_q.push_back(x);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_obs();
        got_q.delete();
        done_cnt = 0;
        rh_cnt   = 0;
        rh_bad   = 0;
    endtask

    // Returns at posedge+1 of the cycle the DUT is in SNAP
    task automatic start_pulse();
        @(posedge clkin); #1 start = 1'b1;
        @(posedge clkin); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clkin); #1;
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    // Monitor: captures transfers, checks stall stability, tracks done/resethist
    initial begin
        forever begin
            @(negedge clkin);
            cyc++;
            if (nrst) begin
                if (stall_prev) begin
                    check("stall_valid", 32'(tx_valid), 32'd1);
                    check("stall_data", 32'(tx_data), 32'(stall_data));
                end
                if (tx_valid && tx_ready) begin
                    got_q.push_back(tx_data);
                    last_xfer_cyc = cyc;
                end
                stall_prev = tx_valid && !tx_ready;
                stall_data = tx_data;
                if (done) begin
                    done_cnt++;
                    done_cyc  = cyc;
                    done_busy = busy;
                end
                if (resethist) begin
                    rh_cnt++;
                    rh_total++;
                    if (!busy) rh_bad++;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // tx_ready pattern 1,0,0,1 when enabled
    initial begin
        forever begin
            @(posedge clkin); #1;
            if (ready_mode) begin
                tx_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lit [10];
        logic [7:0] x;
        lit = '{8'hA5, 8'h08, 8'h00, 8'h03, 8'h02, 8'h01, 8'h01, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < NBINS; i++) h1[i*BINW +: BINW] = 32'h01020300 + 32'(i);

        nrst      = 1'b0;
        start     = 1'b0;
        tx_ready  = 1'b1;
        hist_flat = h1;
        idle(3);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_resethist", 32'(resethist), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        nrst = 1'b1;
        idle(2);

        // Basic frame at full rate
        clear_obs();
        build_exp(h1);
        start_pulse();
        check("snap_busy", 32'(busy), 32'd1);
        check("snap_valid", 32'(tx_valid), 32'd0);
        idle(1);
        check("hdr_valid", 32'(tx_valid), 32'd1);
        check("hdr_data", 32'(tx_data), 32'hA5);
        wait_done("t1", 100);
        idle(8);
        compare_frame("t1");
        check("t1_flen", 32'(got_q.size()), 32'(FLEN));
        for (int i = 0; i < 10; i++)
            if (i < got_q.size()) check($sformatf("t1_lit%0d", i), 32'(got_q[i]), 32'(lit[i]));
        x = 8'h00;
        for (int i = 0; i < FLEN - 1 && i < got_q.size(); i++) x = x ^ got_q[i];
        if (got_q.size() == FLEN) begin
            check("t1_csum_xor", 32'(got_q[FLEN-1]), 32'(x));
            check("t1_csum_lit", 32'(got_q[FLEN-1]), 32'hAD);
        end
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_done_timing", 32'(done_cyc), 32'(last_xfer_cyc + 1));
        check("t1_done_busy", 32'(done_busy), 32'(CLR_EN));
        check("t1_rh_cycles", 32'(rh_cnt), CLR_EN ? 32'd4 : 32'd0);
        check("t1_rh_busy", 32'(rh_bad), 32'd0);

        // Stalling sink
        clear_obs();
        ph = 0;
        ready_mode = 1'b1;
        start_pulse();
        wait_done("t2", 300);
        ready_mode = 1'b0;
        tx_ready   = 1'b1;
        idle(8);
        compare_frame("t2");
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // Live input changes after the snapshot
        clear_obs();
        start_pulse();
        idle(1);
        hist_flat = {FW{1'b1}};
        wait_done("t3", 100);
        idle(8);
        compare_frame("t3");
        hist_flat = h1;

        // Second start mid-frame
        clear_obs();
        start_pulse();
        idle(10);
        start_pulse();
        wait_done("t4", 100);
        idle(60);
        check("t4_done_cnt", 32'(done_cnt), 32'd1);
        compare_frame("t4");

        // Start held high for 100 cycles
        clear_obs();
        @(posedge clkin); #1 start = 1'b1;
        idle(100);
        start = 1'b0;
        idle(30);
        check("t5_done_cnt", 32'(done_cnt), 32'd1);
        check("t5_len", 32'(got_q.size()), 32'(FLEN));

        // Reset mid-frame at byte 12
        clear_obs();
        start_pulse();
        for (int n = 0; n < 100 && got_q.size() < 12; n++) idle(1);
        check("t6_reached12", 32'(got_q.size()), 32'd12);
        nrst = 1'b0;
        #1;
        check("t6_abort_valid", 32'(tx_valid), 32'd0);
        check("t6_abort_busy", 32'(busy), 32'd0);
        idle(3);
        check("t6_no_extra", 32'(got_q.size()), 32'd12);
        nrst = 1'b1;
        idle(2);
        clear_obs();
        start_pulse();
        wait_done("t6", 100);
        idle(8);
        compare_frame("t6");

`ifdef HIST_CLEAR_AFTER_READ_EN
        // Start during CLEAR is ignored
        clear_obs();
        start_pulse();
        wait_done("t7", 100);
        check("t7_in_clear", 32'(resethist), 32'd1);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(60);
        check("t7_done_cnt", 32'(done_cnt), 32'd1);
        check("t7_len", 32'(got_q.size()), 32'(FLEN));
        check("t7_rh_cycles", 32'(rh_cnt), 32'd4);
        check("t7_rh_busy", 32'(rh_bad), 32'd0);
`else
        check("rh_never", 32'(rh_total), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
